// File: rtl/heap_arbiter_pkg.sv
// Shared types and sizing helpers for the heap array arbiter and its storage.
package heap_arbiter_pkg;

    typedef enum logic [1:0] {
        OP_ALLOC = 2'd0,
        OP_FREE  = 2'd1,
        OP_PUSH  = 2'd2,
        OP_POP   = 2'd3
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam int DEFAULT_N_ARRAYS = 4;
    localparam int DEFAULT_N_AREA   = 3;
    localparam int HEAP_WORDS       = DEFAULT_N_ARRAYS * DEFAULT_N_AREA;

    function automatic int heap_words(input int n_arrays, input int n_area);
        return n_arrays * n_area;
    endfunction

endpackage

// File: rtl/heap_array_store.sv
// Heap element memory plus the per-array size table; combinational read, synchronous write.
module heap_array_store
    import heap_arbiter_pkg::*;
#(
    parameter int W        = 12,
    parameter int NArrays  = 4,
    parameter int NArea    = 3,
    localparam int HeapWords = heap_words(NArrays, NArea),
    localparam int AddrW     = (HeapWords > 1) ? $clog2(HeapWords) : 1,
    localparam int SizeIdxW  = (NArrays > 1) ? $clog2(NArrays) : 1
) (
    input  logic                clock,
    input  logic [AddrW-1:0]    heap_addr,
    input  logic                heap_we,
    input  logic [W-1:0]        heap_wdata,
    output logic [W-1:0]        heap_rdata,
    input  logic [SizeIdxW-1:0] size_addr,
    input  logic                size_we,
    input  logic [W-1:0]        size_wdata,
    output logic [W-1:0]        size_rdata
);

    logic [W-1:0] heap_mem [HeapWords];
    logic [W-1:0] size_mem [NArrays];

    // Contents are never reset; the controller rewrites a size whenever it hands out a handle.
    always_ff @(posedge clock) begin
        if (heap_we) begin
            heap_mem[heap_addr] <= heap_wdata;
        end
        if (size_we) begin
            size_mem[size_addr] <= size_wdata;
        end
    end

    assign heap_rdata = heap_mem[heap_addr];
    assign size_rdata = size_mem[size_addr];

endmodule

// File: rtl/heap_array_arbiter.sv
// Round-robin arbiter that serialises ALLOC/FREE/PUSH/POP requests onto one shared array heap.
module heap_array_arbiter
    import heap_arbiter_pkg::*;
#(
    parameter int MemoryElementWidth = 12,
    parameter int NReq               = 2,
    parameter int NArea              = 3,
    parameter int NArrays            = 4,
    localparam int IdWidth           = (NReq > 1) ? $clog2(NReq) : 1
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [NReq-1:0]                 req_valid,
    input  logic [2*NReq-1:0]               req_op,
    input  logic [MemoryElementWidth*NReq-1:0] req_array,
    input  logic [MemoryElementWidth*NReq-1:0] req_data,
    output logic [NReq-1:0]                 req_ready,
    output logic                            rsp_valid,
    output logic [IdWidth-1:0]              rsp_id,
    output logic [MemoryElementWidth-1:0]   rsp_data,
    output logic                            rsp_error,
    output logic                            busy
);

    localparam int W         = MemoryElementWidth;
    localparam int HeapWords = heap_words(NArrays, NArea);
    localparam int AddrW     = (HeapWords > 1) ? $clog2(HeapWords) : 1;
    localparam int SizeIdxW  = (NArrays > 1) ? $clog2(NArrays) : 1;
    localparam int TopW      = $clog2(NArrays + 1);
    localparam logic [W-1:0] NArraysW = W'(NArrays);
    localparam logic [W-1:0] NAreaW   = W'(NArea);

    state_t               state_reg, state_next;
    logic [IdWidth-1:0]   rr_reg, id_reg;
    op_t                  op_reg;
    logic [W-1:0]         array_reg, data_reg;
    logic [W-1:0]         result_reg;
    logic                 error_reg;
    logic [W-1:0]         allocs_reg;
    logic [TopW-1:0]      top_reg;
    logic [W-1:0]         freed_stack_reg [NArrays];
    logic [NArrays-1:0]   allocated_reg;

    op_t                  op_arr    [NReq];
    logic [W-1:0]         array_arr [NReq];
    logic [W-1:0]         data_arr  [NReq];

    genvar gi;
    generate
        for (gi = 0; gi < NReq; gi++) begin : g_unpack
            assign op_arr[gi]    = op_t'(req_op[2*gi +: 2]);
            assign array_arr[gi] = req_array[W*gi +: W];
            assign data_arr[gi]  = req_data[W*gi +: W];
        end
    endgenerate

    // Search starts one past the last winner so every requester gets a turn.
    logic               grant_found;
    logic [IdWidth-1:0] grant_idx;
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 1; k <= NReq; k++) begin
            if (!grant_found && req_valid[(int'(rr_reg) + k) % NReq]) begin
                grant_found = 1'b1;
                grant_idx   = IdWidth'((int'(rr_reg) + k) % NReq);
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (grant_found) state_next = S_EXEC;
            S_EXEC:  state_next = S_RESP;
            S_RESP:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    logic                stack_nonempty, alloc_ok, handle_ok, is_alloc, exec;
    logic [W-1:0]        alloc_handle, target, cur_size, heap_rdata;
    logic [SizeIdxW-1:0] size_idx;
    logic [AddrW-1:0]    heap_addr;
    logic                heap_we, size_we;
    logic [W-1:0]        size_wdata, exec_result;
    logic                exec_err, alloc_take, alloc_fresh, free_push, set_alloc, clr_alloc;

    assign exec           = (state_reg == S_EXEC);
    assign stack_nonempty = (top_reg != '0);
    assign alloc_handle   = stack_nonempty ? freed_stack_reg[SizeIdxW'(top_reg - TopW'(1))] : allocs_reg;
    assign alloc_ok       = stack_nonempty || (allocs_reg < NArraysW);
    assign target         = (op_reg == OP_ALLOC) ? alloc_handle : array_reg;
    assign handle_ok      = (array_reg < NArraysW);
    assign size_idx       = SizeIdxW'(target);
    assign is_alloc       = allocated_reg[size_idx];
    // POP reads the slot below the current size, PUSH writes at it.
    assign heap_addr      = AddrW'(int'(size_idx) * NArea + int'(cur_size)
                                   - ((op_reg == OP_POP) ? 1 : 0));

    always_comb begin
        heap_we     = 1'b0;
        size_we     = 1'b0;
        size_wdata  = '0;
        exec_err    = 1'b0;
        exec_result = '0;
        alloc_take  = 1'b0;
        alloc_fresh = 1'b0;
        free_push   = 1'b0;
        set_alloc   = 1'b0;
        clr_alloc   = 1'b0;
        if (exec) begin
            case (op_reg)
                OP_ALLOC: begin
                    if (alloc_ok) begin
                        size_we     = 1'b1;
                        set_alloc   = 1'b1;
                        exec_result = alloc_handle;
                        alloc_take  = stack_nonempty;
                        alloc_fresh = !stack_nonempty;
                    end else begin
                        exec_err = 1'b1;
                    end
                end
                OP_FREE: begin
                    if (handle_ok && is_alloc) begin
                        free_push = 1'b1;
                        clr_alloc = 1'b1;
                    end else begin
                        exec_err = 1'b1;
                    end
                end
                OP_PUSH: begin
                    if (handle_ok && is_alloc && (cur_size < NAreaW)) begin
                        heap_we    = 1'b1;
                        size_we    = 1'b1;
                        size_wdata = cur_size + W'(1);
                    end else begin
                        exec_err = 1'b1;
                    end
                end
                OP_POP: begin
                    if (handle_ok && is_alloc && (cur_size != '0)) begin
                        size_we     = 1'b1;
                        size_wdata  = cur_size - W'(1);
                        exec_result = heap_rdata;
                    end else begin
                        exec_err = 1'b1;
                    end
                end
                default: exec_err = 1'b1;
            endcase
        end
    end

    heap_array_store #(
        .W       (W),
        .NArrays (NArrays),
        .NArea   (NArea)
    ) u_store (
        .clock      (clock),
        .heap_addr  (heap_addr),
        .heap_we    (heap_we),
        .heap_wdata (data_reg),
        .heap_rdata (heap_rdata),
        .size_addr  (size_idx),
        .size_we    (size_we),
        .size_wdata (size_wdata),
        .size_rdata (cur_size)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg     <= S_IDLE;
            rr_reg        <= IdWidth'(NReq - 1);
            id_reg        <= '0;
            op_reg        <= OP_ALLOC;
            array_reg     <= '0;
            data_reg      <= '0;
            result_reg    <= '0;
            error_reg     <= 1'b0;
            allocs_reg    <= '0;
            top_reg       <= '0;
            allocated_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == S_IDLE && grant_found) begin
                rr_reg    <= grant_idx;
                id_reg    <= grant_idx;
                op_reg    <= op_arr[grant_idx];
                array_reg <= array_arr[grant_idx];
                data_reg  <= data_arr[grant_idx];
            end
            if (exec) begin
                result_reg <= exec_result;
                error_reg  <= exec_err;
            end
            if (alloc_fresh) allocs_reg <= allocs_reg + W'(1);
            if (alloc_take)  top_reg    <= top_reg - TopW'(1);
            if (free_push)   top_reg    <= top_reg + TopW'(1);
            if (set_alloc)   allocated_reg[size_idx] <= 1'b1;
            if (clr_alloc)   allocated_reg[size_idx] <= 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (free_push) begin
            freed_stack_reg[SizeIdxW'(top_reg)] <= array_reg;
        end
    end

    assign req_ready = (state_reg == S_IDLE && grant_found && !reset)
                       ? (NReq'(1) << grant_idx) : '0;
    assign rsp_valid = (state_reg == S_RESP);
    assign rsp_id    = rsp_valid ? id_reg : '0;
    assign rsp_data  = rsp_valid ? result_reg : '0;
    assign rsp_error = rsp_valid & error_reg;
    assign busy      = (state_reg != S_IDLE);

endmodule
